i2c_apb_cmd_sequencer: RTL
==========================

Name: i2c_apb_cmd_sequencer

Overview:
- Upstream APB master that drives the I2C master's register port on pclk_i, so system logic does not have to hand-code register accesses.
- Accepts one transaction request: slave address, rw, length 1..16 and prescaler.
- Write data arrives on a valid/ready byte stream and is loaded into the TX FIFO. Read data is drained from the RX FIFO onto a valid/ready byte stream.
- Sequences core reset, configuration, enable, status polling and shutdown, then reports done/error.

Parameters:
- POLL_LIMIT, 16'hFFFF: maximum consecutive status polls per wait before timeout.
- TX_DEPTH, 16: TX FIFO capacity. The maximum transaction length equals this value.

Ports:
- pclk_i  in  1  clock (APB clock domain)
- preset_i  in  1  synchronous active-high reset
- req_valid_i  in  1  transaction request valid
- req_ready_o  out  1  high only in IDLE
- req_addr_i  in  7  7-bit slave address
- req_rw_i  in  1  1 = read, 0 = write
- req_len_i  in  4  byte count minus 1 (0 → 1 byte, 15 → 16 bytes)
- req_prescaler_i  in  8  value written to prescaler register
- wr_data_i  in  8  write byte
- wr_valid_i  in  1  write byte valid
- wr_ready_o  out  1  write byte accepted this cycle
- rd_data_o  out  8  read byte
- rd_valid_o  out  1  read byte valid, held until rd_ready_i
- rd_ready_i  in  1  consumer ready
- busy_o  out  1  high whenever state is not IDLE
- done_o  out  1  one-cycle pulse at transaction end
- err_o  out  1  valid with done_o; 1 = poll timeout
- psel_o, penable_o, pwrite_o  out  1 each  APB control
- paddr_o  out  8  APB address
- pwdata_o  out  8  APB write data
- prdata_i  in  8  APB read data
- pready_i  in  1  APB ready

Behaviour:
- Register map:
  - 0x00 prescaler
  - 0x01 cmd: bit7 repeat_start, bit6 enable, bit5 core reset_n
  - 0x02 transmit
  - 0x03 receive
  - 0x04 address_rw = {addr[6:0], rw}
  - 0x05 status: bit7 tx_empty, bit6 rx_full, bit5 rx_empty
- Reset (preset_i high at a clock edge):
  - All outputs go to 0, except req_ready_o = 1.
  - State goes to IDLE and all counters clear.
  - Any in-flight APB transfer is abandoned: psel_o and penable_o are low on the next cycle.
- APB transfer:
  - SETUP cycle: psel=1, penable=0.
  - ACCESS: psel=1, penable=1, held until pready_i=1.
  - prdata_i is sampled in the pready_i=1 cycle.
  - Minimum 2 cycles per transfer; psel drops for at least 1 cycle between transfers.
  - paddr, pwrite and pwdata are stable from SETUP through the end of ACCESS.
- FSM states and transitions:
  - IDLE: on req_valid_i, latch addr, rw, len and prescaler → CMD_RST.
  - CMD_RST: write 0x01 ← 0x00 (core reset asserted) → CFG_PRE.
  - CFG_PRE: write 0x00 ← prescaler → CFG_ADR.
  - CFG_ADR: write 0x04 ← {addr, rw} → TX_LOAD if write, else EN.
  - TX_LOAD:
    - wr_ready_o=1 only while waiting for a byte and no APB transfer is active.
    - Each accepted byte is written to 0x02.
    - After len+1 bytes → EN.
    - wr_valid_i low simply stalls; there is no timeout while loading.
  - EN: write 0x01 ← 0x60 (enable, reset_n) → WAIT_TX if write, else WAIT_RX.
  - WAIT_TX: read 0x05 repeatedly until bit7=1 → FIN.
  - WAIT_RX: read 0x05 repeatedly until bit5=0 → RD_BYTE.
  - RD_BYTE:
    - Read 0x03, then present the byte with rd_valid_o=1.
    - On rd_ready_i, count the byte.
    - If count = len+1 → FIN, else → WAIT_RX.
    - No APB activity while rd_valid_o is waiting on rd_ready_i (backpressure reaches the RX FIFO).
  - FIN: write 0x01 ← 0x20 (disabled, out of reset) → DONE.
  - DONE: done_o=1, err_o=0 for one cycle → IDLE.
- Timeout:
  - The poll counter clears on entry to each WAIT state.
  - When the counter reaches POLL_LIMIT without its exit condition → ABORT.
  - ABORT: write 0x01 ← 0x00 → DONE with err_o=1.
- Other rules:
  - req_valid_i outside IDLE is ignored; req_ready_o=0 there.
  - Byte counter is 5 bits and never wraps; len+1 is at most 16 = TX_DEPTH.
  - A write handshake and an APB transfer never start in the same cycle.

Decomposition:
- Package i2c_seq_pkg:
  - register address constants (PRESC 0x00, CMD 0x01, TX 0x02, RX 0x03, ADDR 0x04, STATUS 0x05)
  - cmd values (0x00, 0x20, 0x60)
  - status bit indices (7, 6, 5)
  - FSM state enum
- One sub-module, apb_xfer_engine: a single-transfer APB master.
  - Inputs: start, addr, wdata, write.
  - Outputs: done pulse, rdata, plus the APB pins.
  - The top-level FSM issues every register access through this engine.

Test Plan:
- Write transaction: req addr=0x50, rw=0, len=2, prescaler=0x04; stream 0xA1, 0xB2, 0xC3 with pready tied 1.
  - APB writes in order: 0x01←0x00, 0x00←0x04, 0x04←0xA0, 0x02←A1/B2/C3, 0x01←0x60.
  - Status polls return 0x00 twice then 0x80 → 0x01←0x20, then done_o=1, err_o=0.
- Read transaction: addr=0x50, rw=1, len=1.
  - Status reads return 0x20 then 0x00; receive reads return 0x5A, then 0x3C.
  - Expect 0x04←0xA1, rd_data 0x5A then 0x3C, then 0x01←0x20 and done.
- Backpressure:
  - Hold rd_ready_i=0 for 10 cycles with rd_valid_o=1 → rd_data_o stable and psel_o=0 throughout.
  - Stall wr_valid_i mid-load → no 0x02 write until a byte arrives.
- Wait states: pready_i low for 3 cycles on each ACCESS → address, data and control stable, and each transfer takes 5 cycles.
- Timeout: POLL_LIMIT=4 and status stuck at 0x00 in WAIT_TX → exactly 4 polls, then 0x01←0x00, done_o=1, err_o=1.
- Reset mid-operation:
  - Assert preset_i during the ACCESS phase of the 0x00 write → next cycle psel_o=0, busy_o=0, req_ready_o=1.
  - A new request then completes normally.

Source files
------------

// File: rtl/i2c_seq_pkg.sv
// Shared constants and state types for the I2C APB command sequencer:
// I2C master register map, cmd values, status bits and FSM encodings.
package i2c_seq_pkg;

  localparam logic [7:0] REG_PRESC  = 8'h00;
  localparam logic [7:0] REG_CMD    = 8'h01;
  localparam logic [7:0] REG_TX     = 8'h02;
  localparam logic [7:0] REG_RX     = 8'h03;
  localparam logic [7:0] REG_ADDR   = 8'h04;
  localparam logic [7:0] REG_STATUS = 8'h05;

  localparam logic [7:0] CMD_OFF  = 8'h00;  // core held in reset
  localparam logic [7:0] CMD_IDLE = 8'h20;  // out of reset, disabled
  localparam logic [7:0] CMD_RUN  = 8'h60;  // enabled, out of reset

  localparam int unsigned ST_TX_EMPTY = 7;
  localparam int unsigned ST_RX_FULL  = 6;
  localparam int unsigned ST_RX_EMPTY = 5;

  typedef enum logic [3:0] {
    S_IDLE, S_CMD_RST, S_CFG_PRE, S_CFG_ADR, S_TX_LOAD, S_EN,
    S_WAIT_TX, S_WAIT_RX, S_RD_BYTE, S_FIN, S_ABORT, S_DONE
  } seq_state_t;

  typedef enum logic [1:0] {XF_IDLE, XF_SETUP, XF_ACCESS} xfer_state_t;

endpackage

// File: rtl/apb_xfer_engine.sv
// Single-transfer APB master: SETUP then ACCESS until pready; registered
// done pulse and read data appear the cycle after the transfer completes.
module apb_xfer_engine
  import i2c_seq_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_start,
  input  logic [7:0] i_addr,
  input  logic [7:0] i_wdata,
  input  logic       i_write,
  output logic       o_done,
  output logic [7:0] o_rdata,
  output logic       o_psel,
  output logic       o_penable,
  output logic       o_pwrite,
  output logic [7:0] o_paddr,
  output logic [7:0] o_pwdata,
  input  logic [7:0] i_prdata,
  input  logic       i_pready
);

  xfer_state_t r_state, w_state_nxt;
  logic        r_done, r_pwrite;
  logic [7:0]  r_rdata, r_paddr, r_pwdata;
  logic        w_xfer_end;

  assign w_xfer_end = (r_state == XF_ACCESS) && i_pready;

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      XF_IDLE:   if (i_start) w_state_nxt = XF_SETUP;
      XF_SETUP:  w_state_nxt = XF_ACCESS;
      XF_ACCESS: if (i_pready) w_state_nxt = XF_IDLE;
      default:   w_state_nxt = XF_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= XF_IDLE;
      r_done   <= 1'b0;
      r_rdata  <= '0;
      r_paddr  <= '0;
      r_pwdata <= '0;
      r_pwrite <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= w_xfer_end;
      // Address/data/direction latch at start and hold through ACCESS
      if (r_state == XF_IDLE && i_start) begin
        r_paddr  <= i_addr;
        r_pwdata <= i_wdata;
        r_pwrite <= i_write;
      end
      if (w_xfer_end && !r_pwrite) r_rdata <= i_prdata;
    end
  end

  assign o_done    = r_done;
  assign o_rdata   = r_rdata;
  assign o_psel    = (r_state != XF_IDLE);
  assign o_penable = (r_state == XF_ACCESS);
  assign o_pwrite  = r_pwrite;
  assign o_paddr   = r_paddr;
  assign o_pwdata  = r_pwdata;

endmodule

// File: rtl/i2c_apb_cmd_sequencer.sv
// Sequences one I2C master transaction over APB: reset, configure, load TX,
// enable, poll status, drain RX and shut down, then report done/error.
module i2c_apb_cmd_sequencer
  import i2c_seq_pkg::*;
#(
  parameter logic [15:0] POLL_LIMIT = 16'hFFFF,
  parameter int unsigned TX_DEPTH   = 16
) (
  input  logic       pclk_i,
  input  logic       preset_i,
  input  logic       req_valid_i,
  output logic       req_ready_o,
  input  logic [6:0] req_addr_i,
  input  logic       req_rw_i,
  input  logic [3:0] req_len_i,
  input  logic [7:0] req_prescaler_i,
  input  logic [7:0] wr_data_i,
  input  logic       wr_valid_i,
  output logic       wr_ready_o,
  output logic [7:0] rd_data_o,
  output logic       rd_valid_o,
  input  logic       rd_ready_i,
  output logic       busy_o,
  output logic       done_o,
  output logic       err_o,
  output logic       psel_o,
  output logic       penable_o,
  output logic       pwrite_o,
  output logic [7:0] paddr_o,
  output logic [7:0] pwdata_o,
  input  logic [7:0] prdata_i,
  input  logic       pready_i
);

  localparam int unsigned CNT_W = $clog2(TX_DEPTH) + 1;

  seq_state_t       r_state, w_state_nxt;
  logic [6:0]       r_addr;
  logic             r_rw, r_sent, r_have, r_rd_valid, r_err;
  logic [3:0]       r_len;
  logic [7:0]       r_presc, r_wbyte, r_rd_data;
  logic [CNT_W-1:0] r_cnt;
  logic [15:0]      r_poll;

  logic       w_start, w_pwrite, w_xdone, w_last, w_poll_out, w_wr_ready;
  logic       w_take_wr, w_cnt_inc, w_poll_inc, w_rd_load, w_rd_ack, w_err_set;
  logic [7:0] w_paddr, w_pwdata, w_xrdata;

  assign w_last     = (r_cnt == CNT_W'(r_len));
  assign w_poll_out = (r_poll == 16'(POLL_LIMIT - 16'd1));

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_paddr     = REG_CMD;
    w_pwdata    = '0;
    w_pwrite    = 1'b1;
    w_wr_ready  = 1'b0;
    w_take_wr   = 1'b0;
    w_cnt_inc   = 1'b0;
    w_poll_inc  = 1'b0;
    w_rd_load   = 1'b0;
    w_rd_ack    = 1'b0;
    w_err_set   = 1'b0;
    unique case (r_state)
      S_IDLE: if (req_valid_i) w_state_nxt = S_CMD_RST;
      S_CMD_RST: begin
        w_pwdata = CMD_OFF;
        w_start  = !r_sent;
        if (w_xdone) w_state_nxt = S_CFG_PRE;
      end
      S_CFG_PRE: begin
        w_paddr  = REG_PRESC;
        w_pwdata = r_presc;
        w_start  = !r_sent;
        if (w_xdone) w_state_nxt = S_CFG_ADR;
      end
      S_CFG_ADR: begin
        w_paddr  = REG_ADDR;
        w_pwdata = {r_addr, r_rw};
        w_start  = !r_sent;
        if (w_xdone) w_state_nxt = r_rw ? S_EN : S_TX_LOAD;
      end
      S_TX_LOAD: begin
        // Byte is captured first and written on a later cycle, so a write
        // handshake never coincides with an APB start.
        w_paddr    = REG_TX;
        w_pwdata   = r_wbyte;
        w_wr_ready = !r_have && !r_sent;
        w_take_wr  = w_wr_ready && wr_valid_i;
        w_start    = r_have && !r_sent;
        if (w_xdone) begin
          w_cnt_inc = 1'b1;
          if (w_last) w_state_nxt = S_EN;
        end
      end
      S_EN: begin
        w_pwdata = CMD_RUN;
        w_start  = !r_sent;
        if (w_xdone) w_state_nxt = r_rw ? S_WAIT_RX : S_WAIT_TX;
      end
      S_WAIT_TX, S_WAIT_RX: begin
        w_paddr  = REG_STATUS;
        w_pwrite = 1'b0;
        w_start  = !r_sent;
        if (w_xdone) begin
          if (r_state == S_WAIT_TX && w_xrdata[ST_TX_EMPTY])
            w_state_nxt = S_FIN;
          else if (r_state == S_WAIT_RX && !w_xrdata[ST_RX_EMPTY])
            w_state_nxt = S_RD_BYTE;
          else if (w_poll_out)
            w_state_nxt = S_ABORT;
          else
            w_poll_inc = 1'b1;
        end
      end
      S_RD_BYTE: begin
        w_paddr   = REG_RX;
        w_pwrite  = 1'b0;
        w_start   = !r_sent && !r_rd_valid;
        w_rd_load = w_xdone;
        if (r_rd_valid && rd_ready_i) begin
          w_rd_ack    = 1'b1;
          w_cnt_inc   = 1'b1;
          w_state_nxt = w_last ? S_FIN : S_WAIT_RX;
        end
      end
      S_FIN: begin
        w_pwdata = CMD_IDLE;
        w_start  = !r_sent;
        if (w_xdone) w_state_nxt = S_DONE;
      end
      S_ABORT: begin
        w_pwdata  = CMD_OFF;
        w_start   = !r_sent;
        w_err_set = w_xdone;
        if (w_xdone) w_state_nxt = S_DONE;
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge pclk_i) begin
    if (preset_i) begin
      r_state    <= S_IDLE;
      r_addr     <= '0;
      r_rw       <= 1'b0;
      r_len      <= '0;
      r_presc    <= '0;
      r_sent     <= 1'b0;
      r_have     <= 1'b0;
      r_wbyte    <= '0;
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
      r_err      <= 1'b0;
      r_cnt      <= '0;
      r_poll     <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == S_IDLE) begin
        r_cnt <= '0;
        if (req_valid_i) begin
          r_addr  <= req_addr_i;
          r_rw    <= req_rw_i;
          r_len   <= req_len_i;
          r_presc <= req_prescaler_i;
          r_err   <= 1'b0;
        end
      end else if (w_cnt_inc) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
      if (w_start)      r_sent <= 1'b1;
      else if (w_xdone) r_sent <= 1'b0;
      if (w_take_wr) begin
        r_have  <= 1'b1;
        r_wbyte <= wr_data_i;
      end else if (w_xdone) begin
        r_have <= 1'b0;
      end
      if (w_rd_load) begin
        r_rd_valid <= 1'b1;
        r_rd_data  <= w_xrdata;
      end else if (w_rd_ack) begin
        r_rd_valid <= 1'b0;
      end
      if (w_err_set) r_err <= 1'b1;
      // Poll count restarts on every state change, i.e. on entry to a WAIT state
      if (w_state_nxt != r_state) r_poll <= '0;
      else if (w_poll_inc)        r_poll <= r_poll + 16'd1;
    end
  end

  apb_xfer_engine u_xfer (
    .i_clk     (pclk_i),
    .i_rst     (preset_i),
    .i_start   (w_start),
    .i_addr    (w_paddr),
    .i_wdata   (w_pwdata),
    .i_write   (w_pwrite),
    .o_done    (w_xdone),
    .o_rdata   (w_xrdata),
    .o_psel    (psel_o),
    .o_penable (penable_o),
    .o_pwrite  (pwrite_o),
    .o_paddr   (paddr_o),
    .o_pwdata  (pwdata_o),
    .i_prdata  (prdata_i),
    .i_pready  (pready_i)
  );

  assign req_ready_o = (r_state == S_IDLE);
  assign busy_o      = (r_state != S_IDLE);
  assign done_o      = (r_state == S_DONE);
  assign err_o       = (r_state == S_DONE) && r_err;
  assign wr_ready_o  = w_wr_ready;
  assign rd_valid_o  = r_rd_valid;
  assign rd_data_o   = r_rd_data;

endmodule
